dp_tcm_ram: RTL and testbench
=============================

# dp_tcm_ram

Dual-port tightly-coupled RAM, the parametrised successor to the single-port SoC memory. It serves the core's instruction and data interfaces from one word array through two identical req/gnt/rvalid ports. It adds configurable depth, base address and wait states, round-robin arbitration, byte-enable writes and out-of-range error reporting. Memory-mapped flag/result mailbox registers drive the testbench observation outputs.

## Interface
- DEPTH, 16384: number of 32-bit words; power of two, at least 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.
- WAIT_CYCLES, 0: extra cycles between grant and rvalid (0..15).
- FLAG_ADDR, 32'h0010_0000: byte address of the flag mailbox register.
- RESULT_ADDR, 32'h0010_0004: byte address of the result mailbox register.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- pN_req_i  in  1  request, N ∈ {0,1}; held until granted.
- pN_gnt_o  out  1  grant; combinational.
- pN_rvalid_o  out  1  response valid; one-cycle pulse.
- pN_addr_i  in  32  byte address; bits [1:0] are ignored.
- pN_we_i  in  1  1 = write, 0 = read.
- pN_be_i  in  4  byte enables for writes.
- pN_wdata_i  in  32  write data.
- pN_rdata_o  out  32  read data; valid when pN_rvalid_o is high.
- pN_err_o  out  1  error flag, qualified by pN_rvalid_o.
- mem_flag_o  out  32  flag mailbox register.
- mem_result_o  out  32  result mailbox register.

## Operation
**Address decode** (evaluated in this order):
- addr[31:2] == FLAG_ADDR[31:2] → flag mailbox.
- addr[31:2] == RESULT_ADDR[31:2] → result mailbox.
- (addr − BASE_ADDR) < DEPTH*4, unsigned 32-bit → array, word index (addr − BASE_ADDR)[clog2(DEPTH)+1:2].
- anything else → error.

**Port eligibility:**
- Each port owns a down-counter cnt_N, width clog2(WAIT_CYCLES+2).
- cnt_N = 0: port idle, eligible.
- cnt_N = 1: response delivered this cycle; port is still eligible.
- cnt_N > 1: port busy; pN_gnt_o = 0.

**Arbitration:**
- One array/mailbox access per cycle.
- Only one port eligible and requesting → that port wins.
- Both eligible and requesting → the port selected by prio wins.
- prio resets to 0; after any grant, prio = index of the other port.
- pN_gnt_o = pN_req_i & eligible_N & won_N.

**On a grant, at the same clock edge:**
- **Write to array:** only the bytes with be[k]=1 are written, at bits [8k+7:8k].
- **Write to mailbox:** the corresponding mailbox register is written under the same byte-enable rule; the array is untouched.
- **Write to error address:** dropped; no state change.
- **Read from array or mailbox:** the value is captured into response register rdata_q_N.
- **Error-address access (read or write):** rdata_q_N = 0, err_q_N = 1.
- **Writes:** rdata_q_N = 0.
- **Counter:** cnt_N loaded with WAIT_CYCLES+1.
- be is ignored for reads.

**Response:**
- cnt_N decrements each cycle while non-zero.
- pN_rvalid_o = 1 in the cycle where cnt_N == 1.
- pN_rdata_o and pN_err_o are driven from rdata_q_N/err_q_N and hold their values until the next grant on that port.

**Reset:**
- rst_ni low clears rvalid, rdata_q, err_q, cnt and prio for both ports, plus mem_flag_o and mem_result_o, all to 0.
- Responses in flight are discarded and never delivered.
- Array contents are not reset.

## Timing
- Grant is combinational in the request cycle t.
- rvalid occurs at cycle t+1+WAIT_CYCLES.
- WAIT_CYCLES=0: back-to-back grants on the same port in consecutive cycles; one response per cycle per port.
- WAIT_CYCLES=W>0: next grant on a port no earlier than cycle t+1+W, the same cycle as its rvalid.
- Per-port throughput is 1/(W+1). Aggregate throughput is at most 1 access per cycle.
- Both ports requesting continuously with W=0 → strict alternation, each port granted every 2nd cycle.
- Losing port: keeps req high with stable address/data; granted no later than 2 cycles after the loss when W=0.
- A read of a word written in cycle t, granted at t+1 or later, returns the new data. No read-during-write hazard is possible, since there is only one access per cycle.
- Mailbox outputs change on the edge that ends the grant cycle.

## Test plan
- **Reset values:** assert rst_ni=0 mid-traffic → all outputs read 0 on the next sample; a pending rvalid never appears after release.
- **Full-word write/read, W=0:** p1 writes 32'hDEADBEEF, be=4'hF, to BASE+0x40 → gnt same cycle. A p1 read of BASE+0x40 at cycle t → rvalid at t+1 with rdata=32'hDEADBEEF, err=0.
- **Byte enables:** write 32'h11223344 with be=4'b0101 over 32'hDEADBEEF → readback 32'hDE22BE44.
- **Mailbox:** p1 writes 32'h1 to FLAG_ADDR and 32'h2A to RESULT_ADDR → mem_flag_o=1, mem_result_o=42 after the respective edges. Reading FLAG_ADDR returns 1. Array word BASE+0x0 is unchanged.
- **Arbitration, W=0:** both ports request reads every cycle from reset → p0 granted first, then alternating p1, p0, p1. Each rvalid follows its own grant by 1 cycle; no lost or duplicated responses over 100 accesses.
- **Errors and wait states, WAIT_CYCLES=3:** p0 reads BASE+DEPTH*4 → gnt at t, rvalid at t+4 with err=1 and rdata=0. p0 gnt is low at t+1..t+3 and high again at t+4 with req held.

Source files
------------

// File: rtl/dp_tcm_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dp_tcm_ram
//  Description : Dual-port tightly-coupled RAM. Two identical req/gnt/rvalid
//                ports share one word array and two mailbox registers
//                (flag/result). One access per cycle, round-robin arbitration
//                between eligible ports, byte-enable writes, programmable
//                grant-to-rvalid latency and out-of-range error responses.
//  Ports       : clk_i, rst_ni (async, active-low)
//                pN_req_i/pN_gnt_o/pN_rvalid_o  handshake, N in {0,1}
//                pN_addr_i/pN_we_i/pN_be_i/pN_wdata_i  request payload
//                pN_rdata_o/pN_err_o  response payload (qualified by rvalid)
//                mem_flag_o/mem_result_o  mailbox register contents
//  Revision    : 1.0  initial release
// ============================================================================
module dp_tcm_ram #(
    parameter int unsigned DEPTH       = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] FLAG_ADDR   = 32'h0010_0000,
    parameter logic [31:0] RESULT_ADDR = 32'h0010_0004
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        p0_req_i,
    output logic        p0_gnt_o,
    output logic        p0_rvalid_o,
    input  logic [31:0] p0_addr_i,
    input  logic        p0_we_i,
    input  logic [3:0]  p0_be_i,
    input  logic [31:0] p0_wdata_i,
    output logic [31:0] p0_rdata_o,
    output logic        p0_err_o,

    input  logic        p1_req_i,
    output logic        p1_gnt_o,
    output logic        p1_rvalid_o,
    input  logic [31:0] p1_addr_i,
    input  logic        p1_we_i,
    input  logic [3:0]  p1_be_i,
    input  logic [31:0] p1_wdata_i,
    output logic [31:0] p1_rdata_o,
    output logic        p1_err_o,

    output logic [31:0] mem_flag_o,
    output logic [31:0] mem_result_o
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(WAIT_CYCLES + 2);
    localparam logic [CW-1:0] c_LOAD = CW'(WAIT_CYCLES + 1);
    localparam logic [31:0]   c_SPAN = 32'(DEPTH * 4);

    // ------------------------------------------------------------------
    // Port bundling so the shared datapath can index by port number
    // ------------------------------------------------------------------
    logic [1:0]  w_req;
    logic [1:0]  w_we;
    logic [31:0] w_addr  [2];
    logic [3:0]  w_be    [2];
    logic [31:0] w_wdata [2];

    assign w_req      = {p1_req_i, p0_req_i};
    assign w_we       = {p1_we_i,  p0_we_i};
    assign w_addr[0]  = p0_addr_i;
    assign w_addr[1]  = p1_addr_i;
    assign w_be[0]    = p0_be_i;
    assign w_be[1]    = p1_be_i;
    assign w_wdata[0] = p0_wdata_i;
    assign w_wdata[1] = p1_wdata_i;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [31:0]   rdata_q [2];
    logic [31:0]   rdata_d [2];
    logic [1:0]    err_q,  err_d;
    logic          prio_q, prio_d;
    logic [31:0]   flag_q, flag_d;
    logic [31:0]   result_q, result_d;

    // ------------------------------------------------------------------
    // Arbitration. A port whose counter is at 1 is delivering its response
    // this cycle and may already be granted again, which is what gives one
    // access per cycle per port when WAIT_CYCLES is 0.
    // ------------------------------------------------------------------
    logic [1:0] w_elig;
    logic [1:0] w_ok;
    logic [1:0] w_won;
    logic       w_any;
    logic       w_sel;

    assign w_elig[0] = (cnt_q[0] <= CW'(1));
    assign w_elig[1] = (cnt_q[1] <= CW'(1));
    assign w_ok      = w_req & w_elig;
    assign w_won[0]  = w_ok[0] & (~w_ok[1] | ~prio_q);
    assign w_won[1]  = w_ok[1] & (~w_ok[0] |  prio_q);
    assign w_any     = |w_won;
    assign w_sel     = w_won[1];

    assign p0_gnt_o  = w_won[0];
    assign p1_gnt_o  = w_won[1];

    // ------------------------------------------------------------------
    // Address decode of the winning request (mailboxes take precedence)
    // ------------------------------------------------------------------
    logic [31:0]   w_a;
    logic [31:0]   w_off;
    logic          w_hit_flag;
    logic          w_hit_res;
    logic          w_hit_arr;
    logic          w_hit_err;
    logic [AW-1:0] w_idx;
    logic          w_wr;
    logic [3:0]    w_sbe;
    logic [31:0]   w_swd;
    logic [31:0]   w_rd_val;

    assign w_a        = w_addr[w_sel];
    assign w_wr       = w_we[w_sel];
    assign w_sbe      = w_be[w_sel];
    assign w_swd      = w_wdata[w_sel];
    // Unsigned wrap-around makes addresses below BASE_ADDR land out of range.
    assign w_off      = w_a - BASE_ADDR;
    assign w_hit_flag = (w_a[31:2] == FLAG_ADDR[31:2]);
    assign w_hit_res  = ~w_hit_flag & (w_a[31:2] == RESULT_ADDR[31:2]);
    assign w_hit_arr  = ~w_hit_flag & ~w_hit_res & (w_off < c_SPAN);
    assign w_hit_err  = ~w_hit_flag & ~w_hit_res & ~w_hit_arr;
    assign w_idx      = w_off[AW+1:2];

    always_comb begin
        w_rd_val = mem_q[w_idx];
        if (w_hit_flag) begin
            w_rd_val = flag_q;
        end else if (w_hit_res) begin
            w_rd_val = result_q;
        end
    end

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                r[8*k +: 8] = new_v[8*k +: 8];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        flag_d   = flag_q;
        result_d = result_q;
        prio_d   = prio_q;
        err_d    = err_q;
        for (int n = 0; n < 2; n++) begin
            cnt_d[n]   = cnt_q[n];
            rdata_d[n] = rdata_q[n];
            if (cnt_q[n] != '0) begin
                cnt_d[n] = cnt_q[n] - CW'(1);
            end
            if (w_won[n]) begin
                cnt_d[n]   = c_LOAD;
                err_d[n]   = w_hit_err;
                rdata_d[n] = (w_wr | w_hit_err) ? 32'h0 : w_rd_val;
            end
        end
        if (w_any) begin
            prio_d = ~w_sel;
            if (w_wr && w_hit_flag) begin
                flag_d = f_merge(flag_q, w_swd, w_sbe);
            end
            if (w_wr && w_hit_res) begin
                result_d = f_merge(result_q, w_swd, w_sbe);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers with reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            err_q      <= '0;
            prio_q     <= 1'b0;
            flag_q     <= '0;
            result_q   <= '0;
        end else begin
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
            err_q      <= err_d;
            prio_q     <= prio_d;
            flag_q     <= flag_d;
            result_q   <= result_d;
        end
    end

    // Array contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk_i) begin
        if (w_any && w_wr && w_hit_arr) begin
            for (int k = 0; k < 4; k++) begin
                if (w_sbe[k]) begin
                    mem_q[w_idx][8*k +: 8] <= w_swd[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign p0_rvalid_o  = (cnt_q[0] == CW'(1));
    assign p1_rvalid_o  = (cnt_q[1] == CW'(1));
    assign p0_rdata_o   = rdata_q[0];
    assign p1_rdata_o   = rdata_q[1];
    assign p0_err_o     = err_q[0];
    assign p1_err_o     = err_q[1];
    assign mem_flag_o   = flag_q;
    assign mem_result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_tcm_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_tcm_ram
//  Description : Self-checking bench for dp_tcm_ram. Instance A (no wait
//                states) is driven by directed and random traffic and checked
//                every cycle against a cycle-count reference model; instance
//                B (three wait states) gets directed latency/error checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dp_tcm_ram;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WA    = 0;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] FLAG  = 32'h0010_0000;
    localparam logic [31:0] RES   = 32'h0010_0004;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic [1:0]  a_req, a_we, a_gnt, a_rv, a_err;
    logic [31:0] a_addr [2];
    logic [31:0] a_wdata[2];
    logic [3:0]  a_be   [2];
    logic [31:0] a_rdata[2];
    logic [31:0] a_flag, a_res;
    // Instance B signals
    logic [1:0]  b_req, b_we, b_gnt, b_rv, b_err;
    logic [31:0] b_addr [2];
    logic [31:0] b_wdata[2];
    logic [3:0]  b_be   [2];
    logic [31:0] b_rdata[2];
    logic [31:0] b_flag, b_res;

    dp_tcm_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WA),
                 .FLAG_ADDR(FLAG), .RESULT_ADDR(RES)) u_a (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_req_i(a_req[0]), .p0_gnt_o(a_gnt[0]), .p0_rvalid_o(a_rv[0]),
        .p0_addr_i(a_addr[0]), .p0_we_i(a_we[0]), .p0_be_i(a_be[0]),
        .p0_wdata_i(a_wdata[0]), .p0_rdata_o(a_rdata[0]), .p0_err_o(a_err[0]),
        .p1_req_i(a_req[1]), .p1_gnt_o(a_gnt[1]), .p1_rvalid_o(a_rv[1]),
        .p1_addr_i(a_addr[1]), .p1_we_i(a_we[1]), .p1_be_i(a_be[1]),
        .p1_wdata_i(a_wdata[1]), .p1_rdata_o(a_rdata[1]), .p1_err_o(a_err[1]),
        .mem_flag_o(a_flag), .mem_result_o(a_res));

    dp_tcm_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3),
                 .FLAG_ADDR(FLAG), .RESULT_ADDR(RES)) u_b (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_req_i(b_req[0]), .p0_gnt_o(b_gnt[0]), .p0_rvalid_o(b_rv[0]),
        .p0_addr_i(b_addr[0]), .p0_we_i(b_we[0]), .p0_be_i(b_be[0]),
        .p0_wdata_i(b_wdata[0]), .p0_rdata_o(b_rdata[0]), .p0_err_o(b_err[0]),
        .p1_req_i(b_req[1]), .p1_gnt_o(b_gnt[1]), .p1_rvalid_o(b_rv[1]),
        .p1_addr_i(b_addr[1]), .p1_we_i(b_we[1]), .p1_be_i(b_be[1]),
        .p1_wdata_i(b_wdata[1]), .p1_rdata_o(b_rdata[1]), .p1_err_o(b_err[1]),
        .mem_flag_o(b_flag), .mem_result_o(b_res));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model for instance A: tracks, in absolute cycle numbers,
    // when each port may be granted again and when its response is due.
    // ------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_flag, m_res;
    int          m_prio;
    int          m_next[2];
    bit          m_pend[2];
    int          m_due [2];
    logic [31:0] m_rd  [2];
    bit          m_err [2];
    int          tcyc;
    logic [1:0]  obs_gnt;
    int          n_resp, n_grant;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_flag = '0; m_res = '0; m_prio = 0;
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 0; m_next[p] = 0;
        end
    endtask

    // Called right after inputs were set at a falling edge; checks this
    // cycle's outputs, applies the access, then advances to the rising edge.
    task automatic step_a();
        int w, kind;
        bit ok[2];
        bit exp_rv;
        logic [31:0] ad, off, rv;
        #1;
        for (int p = 0; p < 2; p++) ok[p] = a_req[p] && (tcyc >= m_next[p]);
        if (ok[0] && ok[1]) w = m_prio;
        else if (ok[0])     w = 0;
        else if (ok[1])     w = 1;
        else                w = -1;
        obs_gnt = a_gnt;
        chk("A gnt0", a_gnt[0], w == 0);
        chk("A gnt1", a_gnt[1], w == 1);
        for (int p = 0; p < 2; p++) begin
            exp_rv = m_pend[p] && (m_due[p] == tcyc);
            chk(p == 0 ? "A rvalid0" : "A rvalid1", a_rv[p], exp_rv);
            if (exp_rv) begin
                chk(p == 0 ? "A rdata0" : "A rdata1", a_rdata[p], m_rd[p]);
                chk(p == 0 ? "A err0" : "A err1", a_err[p], m_err[p]);
                m_pend[p] = 0;
                n_resp++;
            end
        end
        chk("A flag", a_flag, m_flag);
        chk("A result", a_res, m_res);
        if (w >= 0) begin
            n_grant++;
            ad  = a_addr[w];
            off = ad - BASE;
            if ((ad >> 2) == (FLAG >> 2))     kind = 1;
            else if ((ad >> 2) == (RES >> 2)) kind = 2;
            else if (off < DEPTH * 4)         kind = 3;
            else                              kind = 0;
            rv = (kind == 1) ? m_flag : (kind == 2) ? m_res :
                 (kind == 3) ? m_mem[off / 4] : 32'h0;
            if (a_we[w]) begin
                if (kind == 1) m_flag = merge(m_flag, a_wdata[w], a_be[w]);
                if (kind == 2) m_res  = merge(m_res,  a_wdata[w], a_be[w]);
                if (kind == 3) m_mem[off / 4] = merge(m_mem[off / 4], a_wdata[w], a_be[w]);
            end
            m_pend[w] = 1;
            m_due[w]  = tcyc + 1 + WA;
            m_next[w] = tcyc + 1 + WA;
            m_rd[w]   = (a_we[w] || kind == 0) ? 32'h0 : rv;
            m_err[w]  = (kind == 0);
            m_prio    = 1 - w;
        end
        @(posedge clk);
        tcyc++;
    endtask

    // Single-port access on A; inputs only change at falling edges.
    task automatic op(input int p, input bit we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        a_req = '0;
        a_req[p] = 1'b1; a_we[p] = we; a_addr[p] = addr; a_be[p] = be; a_wdata[p] = wd;
        step_a();
    endtask

    task automatic idle_a();
        @(negedge clk);
        a_req = '0;
        step_a();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return FLAG | 32'($urandom_range(0, 3));
        if (r == 1) return RES  | 32'($urandom_range(0, 3));
        if (r == 2) return ($urandom_range(0, 1) == 0) ? BASE - 32'd4
                                                       : BASE + DEPTH * 4 + 32'($urandom_range(0, 255));
        return BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    task automatic rand_port(input int p);
        a_req[p]   = ($urandom_range(0, 3) != 0);
        a_we[p]    = 1'($urandom_range(0, 1));
        a_addr[p]  = rand_addr();
        a_be[p]    = 4'($urandom);
        a_wdata[p] = $urandom;
    endtask

    // Asynchronous reset mid-cycle: every output must read zero at once.
    task automatic do_reset();
        @(negedge clk);
        a_req = '0; b_req = '0;
        rst_n = 1'b0;
        #1;
        chk("RST A outs", {a_gnt, a_rv, a_err}, '0);
        chk("RST A rdata0", a_rdata[0], '0);
        chk("RST A rdata1", a_rdata[1], '0);
        chk("RST A flag", a_flag, '0);
        chk("RST A result", a_res, '0);
        chk("RST B outs", {b_gnt, b_rv, b_err}, '0);
        chk("RST B rdata0", b_rdata[0], '0);
        chk("RST B flag", b_flag, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] init0;
        int r0, g0;
        a_req = '0; a_we = '0; b_req = '0; b_we = '0;
        for (int p = 0; p < 2; p++) begin
            a_addr[p] = '0; a_wdata[p] = '0; a_be[p] = '0;
            b_addr[p] = '0; b_wdata[p] = '0; b_be[p] = '0;
        end
        tcyc = 0; n_resp = 0; n_grant = 0; init0 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset gnt/rvalid", {a_gnt, a_rv, b_rv}, '0);
        chk("reset flag", a_flag, '0);
        rst_n = 1'b1;

        // Fill the array with known values, back-to-back on p0
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (i == 0) init0 = v;
            op(0, 1'b1, BASE + 32'(i) * 4, 4'hF, v);
        end
        idle_a();

        // Full-word write/read
        op(1, 1'b1, BASE + 32'h40, 4'hF, 32'hDEADBEEF);
        chk("wr gnt same cycle", obs_gnt, 2'b10);
        op(1, 1'b0, BASE + 32'h40, 4'h0, 32'h0);
        #1;
        chk("rd rvalid next cycle", a_rv[1], 1'b1);
        chk("rd DEADBEEF", a_rdata[1], 32'hDEADBEEF);
        chk("rd err", a_err[1], 1'b0);

        // Byte enables
        op(1, 1'b1, BASE + 32'h40, 4'b0101, 32'h11223344);
        op(1, 1'b0, BASE + 32'h40, 4'hF, 32'h0);
        #1;
        chk("byte-enable merge", a_rdata[1], 32'hDE22BE44);

        // Mailboxes
        op(1, 1'b1, FLAG, 4'hF, 32'h1);
        #1;
        chk("flag mailbox", a_flag, 32'h1);
        op(1, 1'b1, RES, 4'hF, 32'h2A);
        #1;
        chk("result mailbox", a_res, 32'd42);
        op(1, 1'b0, FLAG, 4'h0, 32'h0);
        #1;
        chk("flag readback", a_rdata[1], 32'h1);
        op(1, 1'b0, BASE, 4'h0, 32'h0);
        #1;
        chk("array word 0 intact", a_rdata[1], init0);
        idle_a();

        // Arbitration from reset: both ports reading every cycle
        do_reset();
        r0 = n_resp; g0 = n_grant;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            a_req = 2'b11; a_we = 2'b00;
            a_addr[0] = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
            a_addr[1] = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
            step_a();
            chk("alternation", obs_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        idle_a();
        chk("grant count", n_grant - g0, 100);
        chk("response count", n_resp - r0, 100);

        // Random traffic with a reset while a response is in flight
        for (int k = 0; k < 300; k++) begin
            if (k == 150) begin
                op(0, 1'b0, BASE, 4'h0, 32'h0);
                do_reset();
            end
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!(a_req[p] && !obs_gnt[p])) rand_port(p);
            end
            step_a();
        end
        idle_a();
        idle_a();

        // Instance B: three wait states
        @(negedge clk);
        b_req[1] = 1'b1; b_we[1] = 1'b1; b_addr[1] = BASE + 32'h8;
        b_be[1] = 4'hF; b_wdata[1] = 32'hCAFEF00D;
        #1;
        chk("B wr gnt", b_gnt[1], 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            b_req[1] = 1'b0;
            #1;
            chk("B wr rvalid", b_rv[1], k == 4);
            if (k == 4) chk("B wr rdata", b_rdata[1], 32'h0);
        end
        @(negedge clk);
        b_req[1] = 1'b1; b_we[1] = 1'b0;
        #1;
        chk("B rd gnt", b_gnt[1], 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            b_req[1] = 1'b0;
            #1;
            chk("B rd rvalid", b_rv[1], k == 4);
            if (k == 4) begin
                chk("B rd rdata", b_rdata[1], 32'hCAFEF00D);
                chk("B rd err", b_err[1], 1'b0);
            end
        end
        @(negedge clk);
        b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = BASE + DEPTH * 4;
        #1;
        chk("B err gnt t", b_gnt[0], 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk("B gnt held-off", b_gnt[0], k == 4);
            chk("B err rvalid", b_rv[0], k == 4);
            if (k == 4) begin
                chk("B err flag", b_err[0], 1'b1);
                chk("B err rdata", b_rdata[0], 32'h0);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            b_req[0] = 1'b0;
            #1;
            chk("B 2nd rvalid", b_rv[0], k == 4);
            if (k == 4) chk("B 2nd err", b_err[0], 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
